// File: rtl/fifo_stream_reader.sv
// Pops words from an upstream synchronous FIFO (one-cycle read latency) and presents them
// as a valid/ready stream with line framing (m_last every LINE_LEN beats) and a line counter.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 17,
    parameter int LINE_LEN   = 640
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [15:0]           line_cnt,
    output logic [1:0]            dbg_state,
    output logic [1:0]            dbg_occ,
    output logic                  dbg_inflight,
    output logic [15:0]           dbg_beat_cnt
);

    // Stream handshake: a beat transfers on any rising edge where m_valid and m_ready are both
    // high; while m_valid is high and m_ready low, m_data and m_last hold their values.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [15:0] LAST_BEAT = 16'(LINE_LEN - 1);

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [15:0]           beat_cnt_q, beat_cnt_d;
    logic [15:0]           line_cnt_q, line_cnt_d;
    logic                  armed_q, armed_d;

    logic       pop;
    logic       cap;
    logic [2:0] committed;
    logic       room;

    always_comb begin
        pop = (occ_q != 2'd0) & m_ready;
        cap = inflight_q;

        // Words already owned (buffered + inflight) minus the one leaving this cycle.
        // pop implies occ_q >= 1, so the subtraction cannot underflow.
        committed = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        room      = (committed < 3'd2);

        // armed_q keeps pops off until the first clock edge after reset release.
        fifo_rd_en = armed_q & en & ~fifo_empty & room;
    end

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        beat_cnt_d = beat_cnt_q;
        line_cnt_d = line_cnt_q;
        armed_d    = 1'b1;

        // buf0 is always the oldest entry, so a pop shifts buf1 down.
        case ({cap, pop})
            2'b11: begin
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rd_data;
                end else begin
                    buf0_d = fifo_rd_data;
                end
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_rd_data;
                end else begin
                    buf1_d = fifo_rd_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            default: ;
        endcase

        if (pop) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d = 16'd0;
                line_cnt_d = line_cnt_q + 16'd1;
            end else begin
                beat_cnt_d = beat_cnt_q + 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ((occ_q != 2'd0) || inflight_q) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            buf0_q     <= '0;
            buf1_q     <= '0;
            beat_cnt_q <= 16'd0;
            line_cnt_q <= 16'd0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            beat_cnt_q <= beat_cnt_d;
            line_cnt_q <= line_cnt_d;
            armed_q    <= armed_d;
        end
    end

    assign m_valid      = (occ_q != 2'd0);
    assign m_data       = buf0_q;
    assign m_last       = (beat_cnt_q == LAST_BEAT);
    assign line_cnt     = line_cnt_q;
    assign dbg_state    = state_q;
    assign dbg_occ      = occ_q;
    assign dbg_inflight = inflight_q;
    assign dbg_beat_cnt = beat_cnt_q;

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 17: width of a FIFO word and a stream beat.
REQ-002 The block SHALL have parameter LINE_LEN, default 640: beats per line, range 2..65535.
REQ-003 The block SHALL have port clk, input, 1: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1: while high, new FIFO reads are permitted.
REQ-006 The block SHALL have port fifo_empty, input, 1: the upstream sync FIFO holds no data.
REQ-007 The block SHALL have port fifo_rd_en, output, 1: pop request to the FIFO.
REQ-008 The block SHALL have port fifo_rd_data, input, DATA_WIDTH: popped word, valid one cycle after an accepted pop.
REQ-009 The block SHALL have port m_valid, output, 1: a stream beat is presented.
REQ-010 The block SHALL have port m_ready, input, 1: the sink accepts the beat.
REQ-011 The block SHALL have port m_data, output, DATA_WIDTH: beat payload.
REQ-012 The block SHALL have port m_last, output, 1: the beat is the final beat of a line.
REQ-013 The block SHALL have port line_cnt, output, 16: completed lines, wrapping modulo 2^16.

Function
REQ-014 A pop SHALL be accepted when fifo_rd_en=1 and fifo_empty=0; fifo_rd_en SHALL never assert while fifo_empty=1.
REQ-015 Returned data SHALL be captured from fifo_rd_data exactly one cycle after the accepted pop; one inflight flag SHALL track the pending pop.
REQ-016 The block SHALL hold a 2-entry in-order output buffer; occ (0..2) SHALL count valid entries.
REQ-017 fifo_rd_en SHALL equal en & !fifo_empty & ((occ + inflight - pop) < 2), where pop = m_valid & m_ready.
REQ-018 m_valid SHALL equal (occ != 0), and m_data SHALL be the oldest buffer entry.
REQ-019 A beat SHALL transfer on a cycle with m_valid=1 and m_ready=1; m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-020 A simultaneous capture and pop SHALL leave occ unchanged and preserve order.
REQ-021 With en=1, a never-empty FIFO and m_ready held at 1, throughput SHALL be one beat per cycle after a first-beat latency of 2 cycles from the first pop.
REQ-022 Deasserting en SHALL stop new pops only; the inflight word and the buffered words SHALL still drain.
REQ-023 The beat counter beat_cnt (16 bits) SHALL increment on each transfer, and m_last SHALL equal (beat_cnt == LINE_LEN-1).
REQ-024 A transfer with m_last=1 SHALL reset beat_cnt to 0 and increment line_cnt, which wraps from 0xFFFF to 0.
REQ-025 The control FSM SHALL have states IDLE (occ=0, inflight=0, en=0), RUN (en=1) and DRAIN (en=0 with occ or inflight nonzero).
REQ-026 The FSM SHALL transition IDLE->RUN and DRAIN->RUN on en=1, RUN->DRAIN on en=0 with data pending, RUN->IDLE on en=0 with nothing pending, and DRAIN->IDLE when occ=0 and inflight=0.
REQ-027 fifo_empty rising while a pop is inflight SHALL NOT cancel capture of that word.

Reset
REQ-028 While rst=0, the block SHALL asynchronously force the FSM to IDLE, occ=0, inflight=0, beat_cnt=0, line_cnt=0, m_valid=0, m_last=0, m_data=0 and fifo_rd_en=0.
REQ-029 A reset asserted mid-transfer SHALL discard buffered and inflight data, with no beat emitted for them after release.
REQ-030 The first pop after reset release SHALL occur no earlier than the first rising edge of clk with rst=1.

Verification
REQ-031 Streaming: push 0x00001..0x00005, en=1, m_ready=1 -> beats 1..5 in order, one per cycle, first beat 2 cycles after the first fifo_rd_en.
REQ-032 Backpressure: m_ready=0 for 10 cycles with the FIFO non-empty -> occ=2, fifo_rd_en=0, m_data stable; release -> no loss or duplication.
REQ-033 Line framing: LINE_LEN=4, stream 9 beats -> m_last on beats 4 and 8, line_cnt=2, beat_cnt=1.
REQ-034 Disable: drop en the cycle after a pop -> the inflight word is still emitted, FSM passes RUN->DRAIN->IDLE, and no further fifo_rd_en occurs.
REQ-035 Reset mid-operation: assert rst=0 with occ=2 -> m_valid=0 immediately; after release with fifo_empty=1, no beats occur and line_cnt=0.
REQ-036 Empty boundary: fifo_empty toggling every cycle -> fifo_rd_en never asserts while fifo_empty=1, and the output order matches the push order.
